// File: rtl/bpred_pkg.sv
// Shared branch-predictor definitions used by the update queue and counter_table.
package bpred_pkg;

    // Counter index width; must match counter_table.
    localparam int BPRED_WIDTH = 9;

    // Direction encoding for predictions and resolved outcomes.
    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    // One in-flight branch at the default index width.
    // Parameterised users declare the same shape locally with their own width.
    typedef struct packed {
        logic [BPRED_WIDTH-1:0] index;
        logic                   prediction;
    } bpred_entry_t;

    // A resolved branch mispredicted when its direction differs from the prediction.
    function automatic logic is_mispredict(input logic outcome, input logic prediction);
        return outcome ^ prediction;
    endfunction

endpackage

// File: rtl/bpred_fifo.sv
// Pointer/count circular buffer with push, pop and clear.
// The caller only pushes when there is room (or a same-cycle pop makes room).
module bpred_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;

    // Head entry is always presented so the caller can inspect it before popping.
    assign rd_data = mem[rd_ptr];

    // Next occupancy: clear wins, otherwise add push and subtract pop.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    // Pointers, count and registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Entry storage carries no reset; count decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bpred_update_queue.sv
// In-order tracking queue pairing fetch-time predictions with ALU resolutions
// and driving the counter_table update strobe.
//
// Handshake: fetch pushes with i_Push (no back-pressure; watch o_Full, an
// overflow push is dropped and flagged on o_Error). The ALU resolves the
// oldest branch with i_Resolve; a resolve with nothing in flight is dropped
// and flagged. Each accepted resolve yields exactly one o_CT_Enable cycle,
// one cycle later.
module bpred_update_queue
    import bpred_pkg::*;
#(
    parameter int BPRED_WIDTH = bpred_pkg::BPRED_WIDTH,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   i_Reset,
    input  logic                   i_Push,
    input  logic [BPRED_WIDTH-1:0] i_Push_Index,
    input  logic                   i_Push_Prediction,
    input  logic                   i_Resolve,
    input  logic                   i_ALU_Branch_Outcome,
    input  logic                   i_Flush,
    output logic                   o_CT_Enable,
    output logic [BPRED_WIDTH-1:0] o_CT_Index,
    output logic                   o_CT_Outcome,
    output logic                   o_Mispredict,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [CW-1:0]          o_Count,
    output logic                   o_Error
);

    // Same shape as bpred_entry_t, sized by this instance's index width.
    typedef struct packed {
        logic [BPRED_WIDTH-1:0] index;
        logic                   prediction;
    } entry_t;

    entry_t head;
    entry_t push_entry;
    logic   resolve_ok;
    logic   mispredict;
    logic   squash;
    logic   push_ok;
    logic   err_event;

    assign push_entry = '{index: i_Push_Index, prediction: i_Push_Prediction};

    // Accept/squash decisions for this cycle.
    always_comb begin
        resolve_ok = i_Resolve && !o_Empty;
        mispredict = resolve_ok && is_mispredict(i_ALU_Branch_Outcome, head.prediction);
        // A mispredict wipes the younger wrong-path entries just like a flush.
        squash     = i_Flush || mispredict;
        // Full is fine when the oldest entry leaves in the same cycle.
        push_ok    = i_Push && (!o_Full || resolve_ok);
        err_event  = (i_Push && o_Full && !resolve_ok) || (i_Resolve && o_Empty);
    end

    bpred_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (i_Reset),
        .push    (push_ok),
        .wr_data (push_entry),
        .pop     (resolve_ok),
        .clear   (squash),
        .rd_data (head),
        .full    (o_Full),
        .empty   (o_Empty),
        .count   (o_Count)
    );

    // Registered update stage toward counter_table plus error pulse.
    always_ff @(posedge clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_CT_Enable  <= 1'b0;
            o_CT_Index   <= '0;
            o_CT_Outcome <= 1'b0;
            o_Mispredict <= 1'b0;
            o_Error      <= 1'b0;
        end else begin
            o_CT_Enable  <= resolve_ok;
            o_Mispredict <= mispredict;
            o_Error      <= err_event;
            if (resolve_ok) begin
                o_CT_Index   <= head.index;
                o_CT_Outcome <= i_ALU_Branch_Outcome;
            end
        end
    end

endmodule

// File: tb/tb_bpred_update_queue.sv
// Directed bench for bpred_update_queue.
module tb_bpred_update_queue;
    import bpred_pkg::*;

    localparam int W = 9;

    logic         clk;
    logic         i_Reset;
    logic         i_Push;
    logic [W-1:0] i_Push_Index;
    logic         i_Push_Prediction;
    logic         i_Resolve;
    logic         i_ALU_Branch_Outcome;
    logic         i_Flush;
    logic         o_CT_Enable;
    logic [W-1:0] o_CT_Index;
    logic         o_CT_Outcome;
    logic         o_Mispredict;
    logic         o_Full;
    logic         o_Empty;
    logic [2:0]   o_Count;
    logic         o_Error;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    bpred_update_queue #(.BPRED_WIDTH(W), .DEPTH(4)) dut (
        .clk                  (clk),
        .i_Reset              (i_Reset),
        .i_Push               (i_Push),
        .i_Push_Index         (i_Push_Index),
        .i_Push_Prediction    (i_Push_Prediction),
        .i_Resolve            (i_Resolve),
        .i_ALU_Branch_Outcome (i_ALU_Branch_Outcome),
        .i_Flush              (i_Flush),
        .o_CT_Enable          (o_CT_Enable),
        .o_CT_Index           (o_CT_Index),
        .o_CT_Outcome         (o_CT_Outcome),
        .o_Mispredict         (o_Mispredict),
        .o_Full               (o_Full),
        .o_Empty              (o_Empty),
        .o_Count              (o_Count),
        .o_Error              (o_Error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive inputs, let one rising edge pass, sample 1ns later
    task automatic drive(input logic push, input logic [W-1:0] idx, input logic pred,
                         input logic res, input logic outc, input logic flush);
        i_Push               = push;
        i_Push_Index         = idx;
        i_Push_Prediction    = pred;
        i_Resolve            = res;
        i_ALU_Branch_Outcome = outc;
        i_Flush              = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // scoreboard side: push expects a later strobe of that index
    task automatic push_one(input logic [W-1:0] idx);
        exp_q.push_back(idx);
        drive(1'b1, idx, NOT_TAKEN, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve_expect(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        drive(1'b0, '0, 1'b0, 1'b1, NOT_TAKEN, 1'b0);
        check({tag, "_en"}, o_CT_Enable, 1);
        check({tag, "_idx"}, o_CT_Index, e);
        check({tag, "_mis"}, o_Mispredict, 0);
    endtask

    initial begin
        i_Reset = 1'b1;
        i_Push = 0; i_Push_Index = '0; i_Push_Prediction = 0;
        i_Resolve = 0; i_ALU_Branch_Outcome = 0; i_Flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", o_Count, 0);
        check("rst_empty", o_Empty, 1);
        check("rst_full", o_Full, 0);
        check("rst_en", o_CT_Enable, 0);
        check("rst_err", o_Error, 0);
        i_Reset = 1'b0;
        idle();

        // resolve on empty queue
        drive(1'b0, '0, 1'b0, 1'b1, TAKEN, 1'b0);
        check("empty_res_en", o_CT_Enable, 0);
        check("empty_res_err", o_Error, 1);
        check("empty_res_count", o_Count, 0);
        check("empty_res_empty", o_Empty, 1);
        idle();
        check("empty_res_err_clr", o_Error, 0);

        // correct prediction
        drive(1'b1, 9'd5, TAKEN, 1'b0, 1'b0, 1'b0);
        check("cp_count", o_Count, 1);
        check("cp_empty", o_Empty, 0);
        drive(1'b0, '0, 1'b0, 1'b1, TAKEN, 1'b0);
        check("cp_en", o_CT_Enable, 1);
        check("cp_idx", o_CT_Index, 5);
        check("cp_out", o_CT_Outcome, 1);
        check("cp_mis", o_Mispredict, 0);
        check("cp_empty2", o_Empty, 1);
        idle();
        check("cp_en_once", o_CT_Enable, 0);

        // fill and overflow
        for (int k = 1; k <= 4; k++) push_one(W'(k));
        check("fill_count", o_Count, 4);
        check("fill_full", o_Full, 1);
        drive(1'b1, 9'd99, NOT_TAKEN, 1'b0, 1'b0, 1'b0);
        check("ovf_err", o_Error, 1);
        check("ovf_count", o_Count, 4);
        check("ovf_full", o_Full, 1);
        for (int k = 0; k < 4; k++) resolve_expect("drain");
        check("drain_empty", o_Empty, 1);
        check("drain_err", o_Error, 0);
        idle();

        // full push+resolve across pointer wrap
        for (int k = 1; k <= 4; k++) push_one(W'(k));
        for (int k = 0; k < 9; k++) begin
            logic [W-1:0] e;
            logic [W-1:0] nidx;
            nidx = (k == 0) ? 9'd9 : W'(9 + k);
            exp_q.push_back(nidx);
            e = exp_q.pop_front();
            drive(1'b1, nidx, NOT_TAKEN, 1'b1, NOT_TAKEN, 1'b0);
            check("wrap_en", o_CT_Enable, 1);
            check("wrap_idx", o_CT_Index, e);
            check("wrap_count", o_Count, 4);
            check("wrap_err", o_Error, 0);
        end
        for (int k = 0; k < 4; k++) resolve_expect("wrap_drain");
        check("wrap_empty", o_Empty, 1);
        idle();

        // mispredict squash with simultaneous push
        drive(1'b1, 9'd3, TAKEN, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 9'd7, NOT_TAKEN, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 9'd8, TAKEN, 1'b0, 1'b0, 1'b0);
        check("sq_pre_count", o_Count, 3);
        drive(1'b1, 9'd20, NOT_TAKEN, 1'b1, NOT_TAKEN, 1'b0);
        check("sq_en", o_CT_Enable, 1);
        check("sq_idx", o_CT_Index, 3);
        check("sq_out", o_CT_Outcome, 0);
        check("sq_mis", o_Mispredict, 1);
        check("sq_count", o_Count, 0);
        check("sq_empty", o_Empty, 1);
        check("sq_err", o_Error, 0);
        idle();
        check("sq_mis_clr", o_Mispredict, 0);
        check("sq_count2", o_Count, 0);

        // flush with simultaneous resolve
        drive(1'b1, 9'd11, NOT_TAKEN, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 9'd12, NOT_TAKEN, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 9'd30, NOT_TAKEN, 1'b1, NOT_TAKEN, 1'b1);
        check("fl_en", o_CT_Enable, 1);
        check("fl_idx", o_CT_Index, 11);
        check("fl_mis", o_Mispredict, 0);
        check("fl_count", o_Count, 0);
        check("fl_empty", o_Empty, 1);
        idle();

        // reset while a strobe is pending
        drive(1'b1, 9'd13, TAKEN, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 9'd14, TAKEN, 1'b1, NOT_TAKEN, 1'b0);
        check("pre_rst_en", o_CT_Enable, 1);
        check("pre_rst_mis", o_Mispredict, 1);
        i_Push = 0; i_Resolve = 0;
        i_Reset = 1'b1;
        #1;
        check("arst_en", o_CT_Enable, 0);
        check("arst_idx", o_CT_Index, 0);
        check("arst_mis", o_Mispredict, 0);
        check("arst_count", o_Count, 0);
        check("arst_empty", o_Empty, 1);
        #2;
        i_Reset = 1'b0;
        drive(1'b1, 9'd21, TAKEN, 1'b0, 1'b0, 1'b0);
        check("post_rst_count", o_Count, 1);
        drive(1'b0, '0, 1'b0, 1'b1, TAKEN, 1'b0);
        check("post_rst_idx", o_CT_Index, 21);
        check("post_rst_en", o_CT_Enable, 1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
